// File: rtl/bft_leaf_injector.sv
// bft_leaf_injector: turns (dest, len) commands plus payload words into {addr, data} flits for a t_switch leaf port.
module bft_leaf_injector #(
  parameter int N     = 4,
  parameter int A_W   = $clog2(N) + 1,
  parameter int D_W   = 32,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_W-1:0]     cmd_dest,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [D_W-1:0]     pl_data,
  input  logic               pl_valid,
  output logic               pl_ready,
  output logic [A_W+D_W-1:0] m_axis_wdata,
  output logic               m_axis_wvalid,
  input  logic               m_axis_wready,
  output logic               m_axis_wlast,
  output logic               err_dest,
  output logic [31:0]        pkt_cnt,
  output logic [31:0]        flit_cnt,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;
  state_t             state_q, state_d;
  logic [A_W-1:0]     dest_q, dest_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               err_q, err_d;
  logic               out_v_q, out_v_d, out_last_q, out_last_d;
  logic               skid_v_q, skid_v_d, skid_last_q, skid_last_d;
  logic [A_W+D_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [31:0]        pkt_cnt_q, pkt_cnt_d, flit_cnt_q, flit_cnt_d;
  logic               hs_pl, push, drain, main_free, last, to_skid;
  logic [A_W+D_W-1:0] flit;
  always_comb begin
    hs_pl     = pl_valid & pl_ready;
    push      = hs_pl & (state_q == SEND);
    drain     = out_v_q & m_axis_wready;
    main_free = ~out_v_q | drain;
    last      = rem_q == '0;
    flit      = {dest_q, pl_data};
    state_d   = state_q;
    dest_d    = dest_q;
    rem_d     = rem_q;
    err_d     = err_q;
    if (state_q == IDLE && cmd_valid) begin
      dest_d  = cmd_dest;
      rem_d   = cmd_len;
      state_d = int'(cmd_dest) < N ? SEND : DROP;
      err_d   = err_q | (int'(cmd_dest) >= N);
    end else if (hs_pl) begin
      rem_d   = rem_q - LEN_W'(1);
      state_d = last ? IDLE : state_q;
    end
    // A freed main register always takes the skid entry first so flit order is kept.
    to_skid     = push & (skid_v_q | ~main_free);
    out_v_d     = main_free ? (skid_v_q | push) : 1'b1;
    out_data_d  = main_free & skid_v_q ? skid_data_q : main_free & push ? flit : out_data_q;
    out_last_d  = main_free & skid_v_q ? skid_last_q : main_free & push ? last : out_last_q;
    skid_v_d    = main_free ? skid_v_q & push : skid_v_q | push;
    skid_data_d = to_skid ? flit : skid_data_q;
    skid_last_d = to_skid ? last : skid_last_q;
    flit_cnt_d  = drain ? flit_cnt_q + 32'd1 : flit_cnt_q;
    pkt_cnt_d   = drain & out_last_q ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      out_v_q     <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      skid_v_q    <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
      pkt_cnt_q   <= '0;
      flit_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      out_v_q     <= out_v_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      skid_v_q    <= skid_v_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
      pkt_cnt_q   <= pkt_cnt_d;
      flit_cnt_q  <= flit_cnt_d;
    end
  end
  assign cmd_ready     = state_q == IDLE;
  assign pl_ready      = (state_q == SEND & ~skid_v_q) | (state_q == DROP);
  assign m_axis_wdata  = out_data_q;
  assign m_axis_wvalid = out_v_q;
  assign m_axis_wlast  = out_last_q;
  assign err_dest      = err_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign flit_cnt      = flit_cnt_q;
  assign done          = (state_q == IDLE) & ~out_v_q & ~skid_v_q;
endmodule
